// File: rtl/uart_pkg.sv
// Shared UART constants: receiver framing, auto-baud state encodings and sync character.
package uart_pkg;

  localparam int DATA_BITS = 8;

  // Auto-baud sync character, sent LSB first; every bit boundary is a transition.
  localparam logic [7:0] SYNC_CHAR = 8'h55;

  // Interval counter value treated as a lost line.
  localparam logic [14:0] TIMEOUT_CNT = 15'h7FFF;

  // One-hot auto-baud states, same encoding style as the receiver.
  typedef enum logic [5:0] {
    AB_IDLE       = 6'b000001,
    AB_WAIT_HIGH  = 6'b000010,
    AB_WAIT_START = 6'b000100,
    AB_MEASURE    = 6'b001000,
    AB_LOCKED     = 6'b010000,
    AB_ERROR      = 6'b100000
  } ab_state_e;

  // Number of line transitions from the start edge through the last data bit.
  function automatic int sync_transitions(input logic [7:0] ch);
    logic [DATA_BITS:0] seq;
    int n;
    seq = {ch, 1'b0};
    n = 0;
    for (int i = 1; i <= DATA_BITS; i++) begin
      if (seq[i] != seq[i-1]) n++;
    end
    return n;
  endfunction

  // Edge (after the start edge) that closes the measured bit periods.
  localparam int LOCK_EDGES = sync_transitions(SYNC_CHAR);

endpackage

// File: rtl/uart_edge_sync.sv
// Two-flop synchronizer with edge and falling-edge detect; shared with the receiver.
module uart_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic line_o,
  output logic edge_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Synchronize the raw line and keep the previous synchronized sample (idle-high reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= sync_q[1];
    end
  end

  assign line_o = sync_q[1];
  assign edge_o = sync_q[1] ^ prev_q;
  assign fall_o = edge_o & ~sync_q[1];

endmodule

// File: rtl/uart_autobaud.sv
// Auto-baud calibration: measures a 0x55 sync character and sets the receiver bit period.
//
//   state      | meaning
//   IDLE       | never calibrated, BR_Clocks at default
//   WAIT_HIGH  | armed, waiting for an idle-high line
//   WAIT_START | waiting for the start-bit falling edge
//   MEASURE    | timing edge-to-edge intervals
//   LOCKED     | BR_Clocks holds a calibrated value
//   ERROR      | bad interval or timeout, outputs held
module uart_autobaud
  import uart_pkg::*;
#(
  parameter int DEFAULT_BR = 10417,
  parameter int MIN_BR     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rx_Serial,
  input  logic        cal_start,
  output logic [14:0] BR_Clocks,
  output logic        locked,
  output logic        cal_busy,
  output logic        cal_err
);

  ab_state_e   state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic [17:0] acc_q, acc_d;
  logic [3:0]  ecnt_q, ecnt_d;
  logic [15:0] t1_q, t1_d;
  logic [14:0] br_q, br_d;
  logic        locked_q, locked_d;
  logic        rearm_q, rearm_d;

  logic        line_s, edge_s, fall_s;
  logic [15:0] interval;
  logic [16:0] tol_lo, tol_hi;
  logic [17:0] acc_sum;
  logic        first_iv, iv_ok, closing;

  uart_edge_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx_i   (Rx_Serial),
    .line_o (line_s),
    .edge_o (edge_s),
    .fall_o (fall_s)
  );

  // The counter is cleared on the edge cycle, so the interval is count + 1.
  assign interval = {1'b0, cnt_q} + 16'd1;
  assign tol_lo   = {1'b0, t1_q} - {3'b000, t1_q[15:2]};
  assign tol_hi   = {1'b0, t1_q} + {3'b000, t1_q[15:2]};
  assign acc_sum  = acc_q + {2'b00, interval};
  assign first_iv = (ecnt_q == 4'd0);
  assign closing  = (ecnt_q == 4'(LOCK_EDGES - 1));
  assign iv_ok    = first_iv ? (interval >= 16'(MIN_BR))
                             : (({1'b0, interval} >= tol_lo) && ({1'b0, interval} <= tol_hi));

  // State, measurement and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= AB_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      ecnt_q   <= '0;
      t1_q     <= '0;
      br_q     <= 15'(DEFAULT_BR);
      locked_q <= 1'b0;
      rearm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      ecnt_q   <= ecnt_d;
      t1_q     <= t1_d;
      br_q     <= br_d;
      locked_q <= locked_d;
      rearm_q  <= rearm_d;
    end
  end

  // Next-state and datapath updates; results only change on a completed lock.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ecnt_d   = ecnt_q;
    t1_d     = t1_q;
    br_d     = br_q;
    locked_d = locked_q;
    rearm_d  = 1'b0;
    case (state_q)
      AB_IDLE, AB_ERROR: begin
        if (cal_start) state_d = AB_WAIT_HIGH;
      end
      AB_LOCKED: begin
        // A cal_start that coincided with the closing edge re-arms here.
        if (cal_start || rearm_q) state_d = AB_WAIT_HIGH;
      end
      AB_WAIT_HIGH: begin
        if (!cal_start && line_s) state_d = AB_WAIT_START;
      end
      AB_WAIT_START: begin
        if (cal_start) begin
          state_d = AB_WAIT_HIGH;
        end else if (fall_s) begin
          cnt_d   = '0;
          acc_d   = '0;
          ecnt_d  = '0;
          state_d = AB_MEASURE;
        end
      end
      AB_MEASURE: begin
        cnt_d = cnt_q + 15'd1;
        if (edge_s && iv_ok && closing) begin
          state_d  = AB_LOCKED;
          br_d     = acc_sum[17:3];
          locked_d = 1'b1;
          rearm_d  = cal_start;
        end else if (cal_start) begin
          state_d = AB_WAIT_HIGH;
        end else if (edge_s) begin
          if (!iv_ok) begin
            state_d = AB_ERROR;
          end else begin
            cnt_d  = '0;
            acc_d  = acc_sum;
            ecnt_d = ecnt_q + 4'd1;
            if (first_iv) t1_d = interval;
          end
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d = AB_ERROR;
        end
      end
      default: state_d = AB_IDLE;
    endcase
  end

  assign BR_Clocks = br_q;
  assign locked    = locked_q;
  assign cal_busy  = (state_q == AB_WAIT_HIGH) || (state_q == AB_WAIT_START) ||
                     (state_q == AB_MEASURE);
  assign cal_err   = (state_q == AB_ERROR);

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: sync-character locks, errors, aborts and resets.
module tb_uart_autobaud;

  logic        clk = 1'b0;
  logic        rst;
  logic        Rx_Serial;
  logic        cal_start;
  logic [14:0] BR_Clocks;
  logic        locked;
  logic        cal_busy;
  logic        cal_err;

  int total = 0;
  int bad   = 0;
  int jit[10];

  uart_autobaud #(.DEFAULT_BR(10417), .MIN_BR(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .Rx_Serial (Rx_Serial),
    .cal_start (cal_start),
    .BR_Clocks (BR_Clocks),
    .locked    (locked),
    .cal_busy  (cal_busy),
    .cal_err   (cal_err)
  );

  always #5 clk = ~clk;

  task automatic pulse_cal();
    @(negedge clk) cal_start = 1'b1;
    @(negedge clk) cal_start = 1'b0;
  endtask

  // Drive one frame (start, 8 data LSB first, stop); edge k lands at cycle 3 + k*bt + jit[k].
  // cut > 0 stops driving after that many cycles; pulse_edge >= 0 fires cal_start
  // on the cycle the DUT acts on that edge (two synchronizer stages later).
  task automatic send_frame(input logic [7:0] data, input int bt, input int cut, input int pulse_edge);
    logic [9:0] bits;
    int limit;
    int pe;
    logic lvl;
    bits  = {1'b1, data, 1'b0};
    limit = (cut > 0) ? cut : 3 + 9 * bt + 5;
    pe    = (pulse_edge < 0) ? 0 : pulse_edge;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      lvl = 1'b1;
      for (int k = 0; k < 10; k++) begin
        if (c >= 3 + k * bt + jit[k]) lvl = bits[k];
      end
      Rx_Serial = lvl;
      cal_start = (pulse_edge >= 0) && (c == 3 + pe * bt + jit[pe] + 2);
    end
    cal_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; Rx_Serial = 1'b1; cal_start = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (BR_Clocks !== 15'd10417) begin bad++; $display("FAIL reset_br: got %0d want 10417", BR_Clocks); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    total++; if (cal_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", cal_busy); end
    total++; if (cal_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", cal_err); end
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (cal_busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", cal_busy); end
  endtask

  task automatic test_bad_char();
    int n;
    pulse_cal();
    total++; if (cal_busy !== 1'b1) begin bad++; $display("FAIL f0_arm_busy: got %b want 1", cal_busy); end
    send_frame(8'hF0, 100, 0, -1);
    n = 0;
    while (n < 34000 && cal_err !== 1'b1) begin @(negedge clk); n++; end
    total++; if (cal_err !== 1'b1) begin bad++; $display("FAIL f0_err: got %b want 1", cal_err); end
    total++; if (BR_Clocks !== 15'd10417) begin bad++; $display("FAIL f0_br: got %0d want 10417", BR_Clocks); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL f0_locked: got %b want 0", locked); end
    total++; if (cal_busy !== 1'b0) begin bad++; $display("FAIL f0_busy: got %b want 0", cal_busy); end
  endtask

  task automatic test_lock_100();
    pulse_cal();
    total++; if (cal_err !== 1'b0) begin bad++; $display("FAIL rearm_err_clear: got %b want 0", cal_err); end
    total++; if (cal_busy !== 1'b1) begin bad++; $display("FAIL l100_busy_arm: got %b want 1", cal_busy); end
    send_frame(8'h55, 100, 0, -1);
    total++; if (BR_Clocks !== 15'd100) begin bad++; $display("FAIL l100_br: got %0d want 100", BR_Clocks); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL l100_locked: got %b want 1", locked); end
    total++; if (cal_busy !== 1'b0) begin bad++; $display("FAIL l100_busy: got %b want 0", cal_busy); end
  endtask

  task automatic test_jitter_87();
    jit = '{1, -2, 2, 0, -1, 2, -2, 1, 2, 0};
    pulse_cal();
    repeat (20) @(negedge clk);
    total++; if (locked !== 1'b1 || BR_Clocks !== 15'd100) begin bad++; $display("FAIL recal_hold: got locked=%b br=%0d want 1/100", locked, BR_Clocks); end
    send_frame(8'h55, 87, 0, -1);
    jit = '{default: 0};
    // intervals sum to 8*87 + 2 - 1 = 697, floor /8 = 87
    total++; if (BR_Clocks !== 15'd87) begin bad++; $display("FAIL j87_br: got %0d want 87", BR_Clocks); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL j87_locked: got %b want 1", locked); end
  endtask

  task automatic test_min_br();
    pulse_cal();
    send_frame(8'h55, 10, 0, -1);
    total++; if (cal_err !== 1'b1) begin bad++; $display("FAIL minbr_err: got %b want 1", cal_err); end
    total++; if (BR_Clocks !== 15'd87 || locked !== 1'b1) begin bad++; $display("FAIL minbr_hold: got br=%0d locked=%b want 87/1", BR_Clocks, locked); end
  endtask

  task automatic test_abort();
    pulse_cal();
    send_frame(8'h55, 100, 350, -1);
    pulse_cal();
    repeat (2) @(negedge clk);
    total++; if (cal_busy !== 1'b1 || cal_err !== 1'b0) begin bad++; $display("FAIL abort_state: got busy=%b err=%b want 1/0", cal_busy, cal_err); end
    total++; if (BR_Clocks !== 15'd87) begin bad++; $display("FAIL abort_br: got %0d want 87", BR_Clocks); end
    send_frame(8'h55, 100, 0, -1);
    total++; if (BR_Clocks !== 15'd100) begin bad++; $display("FAIL abort_relock_br: got %0d want 100", BR_Clocks); end
  endtask

  task automatic test_coincide();
    pulse_cal();
    send_frame(8'h55, 60, 0, 8);
    repeat (2) @(negedge clk);
    total++; if (BR_Clocks !== 15'd60) begin bad++; $display("FAIL coin_br: got %0d want 60", BR_Clocks); end
    total++; if (locked !== 1'b1 || cal_busy !== 1'b1) begin bad++; $display("FAIL coin_rearm: got locked=%b busy=%b want 1/1", locked, cal_busy); end
    send_frame(8'h55, 100, 0, -1);
    total++; if (BR_Clocks !== 15'd100 || cal_busy !== 1'b0) begin bad++; $display("FAIL coin_next: got br=%0d busy=%b want 100/0", BR_Clocks, cal_busy); end
  endtask

  task automatic test_rst_mid();
    pulse_cal();
    send_frame(8'h55, 100, 250, -1);
    @(negedge clk) rst = 1'b1;
    #1;
    total++; if (BR_Clocks !== 15'd10417) begin bad++; $display("FAIL arst_br: got %0d want 10417", BR_Clocks); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL arst_locked: got %b want 0", locked); end
    total++; if (cal_busy !== 1'b0 || cal_err !== 1'b0) begin bad++; $display("FAIL arst_state: got busy=%b err=%b want 0/0", cal_busy, cal_err); end
    @(negedge clk);
    Rx_Serial = 1'b1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (cal_busy !== 1'b0 || BR_Clocks !== 15'd10417) begin bad++; $display("FAIL arst_idle: got busy=%b br=%0d want 0/10417", cal_busy, BR_Clocks); end
  endtask

  task automatic test_partial_frame();
    @(negedge clk) Rx_Serial = 1'b0;
    repeat (20) @(negedge clk);
    pulse_cal();
    repeat (200) @(negedge clk);
    total++; if (cal_busy !== 1'b1 || BR_Clocks !== 15'd10417) begin bad++; $display("FAIL part_wait: got busy=%b br=%0d want 1/10417", cal_busy, BR_Clocks); end
    @(negedge clk) Rx_Serial = 1'b1;
    repeat (100) @(negedge clk);
    send_frame(8'h55, 50, 0, -1);
    total++; if (BR_Clocks !== 15'd50) begin bad++; $display("FAIL part_br: got %0d want 50", BR_Clocks); end
    total++; if (locked !== 1'b1 || cal_busy !== 1'b0) begin bad++; $display("FAIL part_lock: got locked=%b busy=%b want 1/0", locked, cal_busy); end
  endtask

  task automatic test_timeout();
    int n;
    pulse_cal();
    repeat (5) @(negedge clk);
    @(negedge clk) Rx_Serial = 1'b0;
    n = 0;
    while (n < 34000 && cal_err !== 1'b1) begin @(negedge clk); n++; end
    // 2 sync stages + 1 edge-handling cycle + 32768 counts to 32767 and out
    total++; if (cal_err !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b want 1", cal_err); end
    total++; if (n < 32769 || n > 32773) begin bad++; $display("FAIL tmo_cycles: got %0d want 32771", n); end
    total++; if (BR_Clocks !== 15'd50 || locked !== 1'b1) begin bad++; $display("FAIL tmo_hold: got br=%0d locked=%b want 50/1", BR_Clocks, locked); end
    @(negedge clk) Rx_Serial = 1'b1;
    pulse_cal();
    total++; if (cal_err !== 1'b0 || cal_busy !== 1'b1) begin bad++; $display("FAIL tmo_rearm: got err=%b busy=%b want 0/1", cal_err, cal_busy); end
  endtask

  initial begin
    jit = '{default: 0};
    test_reset();
    test_bad_char();
    test_lock_100();
    test_jitter_87();
    test_min_br();
    test_abort();
    test_coincide();
    test_rst_mid();
    test_partial_frame();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
